// File: rtl/dispatch_rr5.sv
// dispatch_rr5: one-entry holding stage that deals words to NUM_CHILD lanes in strict round-robin.
// Define DISPATCH_RR5_STATS_EN to add the stall_cnt and total_cnt statistics outputs.
module dispatch_rr5 #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           flush,
    output logic [NUM_CHILD-1:0]           out_valid,
    input  logic [NUM_CHILD-1:0]           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [$clog2(NUM_CHILD)-1:0]   ptr,
    output logic [NUM_CHILD*CNT_W-1:0]     lane_cnt,
    output logic                           busy
`ifdef DISPATCH_RR5_STATS_EN
    ,
    output logic [15:0]                    stall_cnt,
    output logic [15:0]                    total_cnt
`endif
);
    localparam int PW = $clog2(NUM_CHILD);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state;
    logic [DATA_W-1:0] hold;
    logic [CNT_W-1:0] cnt [NUM_CHILD];
    logic xfer;
    logic [PW-1:0] ptr_nxt;
    function automatic logic [NUM_CHILD-1:0] onehot(input logic [PW-1:0] p);
        return NUM_CHILD'(1) << p;
    endfunction
    // Only the addressed lane's ready matters; other lanes never steal the word.
    assign xfer     = state == HOLD && out_ready[ptr];
    assign ptr_nxt  = ptr == PW'(NUM_CHILD - 1) ? '0 : ptr + 1'b1;
    assign in_ready = !flush && (state == IDLE || xfer);
    assign busy     = state == HOLD;
    assign out_data = hold;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold      <= '0;
            out_valid <= '0;
            for (int k = 0; k < NUM_CHILD; k++) cnt[k] <= '0;
        end else if (flush) begin
            state     <= IDLE;
            hold      <= '0;
            ptr       <= '0;
            out_valid <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                state     <= HOLD;
                hold      <= in_data;
                out_valid <= onehot(ptr);
            end
        end else if (xfer) begin
            cnt[ptr] <= cnt[ptr] + 1'b1;
            ptr      <= ptr_nxt;
            if (in_valid) begin
                hold      <= in_data;
                out_valid <= onehot(ptr_nxt);
            end else begin
                state     <= IDLE;
                out_valid <= '0;
            end
        end
    end
    for (genvar i = 0; i < NUM_CHILD; i++) begin : g_cnt
        assign lane_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`ifdef DISPATCH_RR5_STATS_EN
    // stall_cnt survives flush so long stalls stay visible across pipeline drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            total_cnt <= '0;
        end else begin
            if (state == HOLD && !out_ready[ptr] && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
            if (xfer && !flush) total_cnt <= total_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dispatch_rr5.sv
// tb_dispatch_rr5: vector table plus scoreboard bench for dispatch_rr5.
// Stats checks are compiled in when DISPATCH_RR5_STATS_EN is defined.
module tb_dispatch_rr5;
    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic in_ready;
    logic [15:0] in_data = '0;
    logic flush = 0;
    logic [4:0] out_valid;
    logic [4:0] out_ready = '0;
    logic [15:0] out_data;
    logic [2:0] ptr;
    logic [39:0] lane_cnt;
    logic busy;
`ifdef DISPATCH_RR5_STATS_EN
    logic [15:0] stall_cnt, total_cnt;
`endif
    int checks = 0;
    int failures = 0;
    logic [15:0] sb_q [$];
    int mptr = 0;

    dispatch_rr5 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ptr(ptr), .lane_cnt(lane_cnt), .busy(busy)
`ifdef DISPATCH_RR5_STATS_EN
        , .stall_cnt(stall_cnt), .total_cnt(total_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    always @(posedge rst) begin
        sb_q.delete();
        mptr = 0;
    end

    // Scoreboard: words pushed on acceptance, popped when a lane takes one.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                sb_q.delete();
                mptr = 0;
            end else begin
                if ((out_valid & out_ready) != 5'b0) begin
                    if (sb_q.size() == 0) chk("sb_unexpected_xfer", 64'(out_valid), 64'h0);
                    else begin
                        logic [4:0] eov;
                        eov = 5'(1) << mptr;
                        chk("sb_lane", 64'(out_valid), 64'(eov));
                        chk("sb_data", 64'(out_data), 64'(sb_q.pop_front()));
                        mptr = (mptr + 1) % 5;
                    end
                end
                if (in_valid && in_ready) sb_q.push_back(in_data);
            end
        end
    end

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [4:0]  ordy;
        logic        e_ir;
        logic [4:0]  e_ov;
        logic [2:0]  e_ptr;
        logic        e_busy;
    } vec_t;
    vec_t tbl [11];

    initial begin
        logic [15:0] s0, t0;
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 16'(i + 1), 5'b11111, 1'b1, 5'(1) << (i % 5), 3'(i % 5), 1'b1};
        tbl[10] = '{1'b0, 16'h0, 5'b11111, 1'b1, 5'b0, 3'd0, 1'b0};

        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ptr", 64'(ptr), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_lane_cnt", 64'(lane_cnt), 0);
        rst = 0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 1);
        cyc();

        // Back-to-back stream of ten words, all lanes ready.
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            cyc();
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("vec%0d_ptr", i), 64'(ptr), 64'(tbl[i].e_ptr));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
        end
        chk("stream_lane_cnt", 64'(lane_cnt), 64'h02_02_02_02_02);

        // Lane 1 not ready: word must wait, no skip to lane 2.
        in_valid = 1; in_data = 16'h0011; out_ready = 5'b11111;
        cyc();
        in_data = 16'hBEEF; out_ready = 5'b11101;
        cyc();
        in_valid = 0;
        for (int i = 0; i < 6; i++) begin
            chk("noskip_out_valid", 64'(out_valid), 64'b00010);
            chk("noskip_out_data", 64'(out_data), 64'hBEEF);
            cyc();
        end
        out_ready = 5'b11111;
        cyc();
        chk("noskip_ptr", 64'(ptr), 2);
        chk("noskip_lane1", 64'(lane_cnt[15:8]), 3);
        chk("noskip_busy", 64'(busy), 0);

        // Flush while holding at lane 3 with lane 3 ready.
        in_valid = 1; in_data = 16'h0033;
        cyc();
        in_data = 16'h0044;
        cyc();
        in_valid = 0; out_ready = 5'b0;
        cyc();
        chk("flush_pre_ptr", 64'(ptr), 3);
        flush = 1; out_ready = 5'b11111; in_valid = 1; in_data = 16'h0055;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 0);
        cyc();
        flush = 0; in_valid = 0;
        chk("flush_out_valid", 64'(out_valid), 0);
        chk("flush_ptr", 64'(ptr), 0);
        chk("flush_busy", 64'(busy), 0);
        chk("flush_lane3", 64'(lane_cnt[31:24]), 2);
        chk("flush_lane2", 64'(lane_cnt[23:16]), 3);

        // Asynchronous reset in the middle of a hold.
        in_valid = 1; in_data = 16'h0066; out_ready = 5'b0;
        cyc();
        in_valid = 0;
        chk("arst_pre_busy", 64'(busy), 1);
        #2 rst = 1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_ptr", 64'(ptr), 0);
        chk("arst_lane_cnt", 64'(lane_cnt), 0);
        #1 rst = 0;
        #0.5;
        chk("arst_in_ready", 64'(in_ready), 1);
        cyc();

        // 1500 words: each lane counter wraps to 300 mod 256.
        in_valid = 1; out_ready = 5'b11111;
        for (int i = 0; i < 1500; i++) begin
            in_data = 16'(i);
            cyc();
        end
        in_valid = 0;
        cyc();
        for (int i = 0; i < 5; i++)
            chk($sformatf("wrap_lane%0d", i), 64'(lane_cnt[i*8 +: 8]), 44);
        chk("wrap_ptr", 64'(ptr), 0);

`ifdef DISPATCH_RR5_STATS_EN
        in_valid = 1;
        cyc();
        cyc();
        in_valid = 0;
        cyc();
        chk("stats_pre_ptr", 64'(ptr), 2);
        s0 = stall_cnt; t0 = total_cnt;
        in_valid = 1; in_data = 16'h0077; out_ready = 5'b0;
        cyc();
        in_valid = 0;
        repeat (7) cyc();
        out_ready = 5'b11111;
        cyc();
        chk("stats_stall", 64'(stall_cnt), 64'(s0 + 16'd7));
        chk("stats_total", 64'(total_cnt), 64'(t0 + 16'd1));
`else
        s0 = '0; t0 = '0;
`endif
        chk("sb_drained", 64'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
